// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_WAIT = 3'd0,
        ST_QUAL = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_LOST = 3'd4
    } sup_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the raw PLL lock into the i_clk domain.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the core in reset until PLL lock is qualified, then watches for loss.
// Define PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN to build the saturating loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 256,
    parameter int HOLD_CYCLES   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_locked,
    input  logic                  i_clear,
    output logic                  o_rst,
    output logic                  o_ready,
    output logic                  o_lock_lost,
    output logic [LOSS_CNT_W-1:0] o_loss_count
);

    // State | meaning
    // WAIT  | no synchronised lock seen, counter idle
    // QUAL  | lock present, counting consecutive stable cycles
    // HOLD  | lock qualified, core reset held a little longer
    // RUN   | core released, any lock drop is a loss
    // LOST  | one-cycle loss marker before re-qualifying

    localparam int CNT_W = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    sup_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_q, ready_q, lost_q, lost_d;
    logic             loss_event;

    pll_lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_locked),
        .o_sync (lock_s)
    );

    // The WAIT cycle that sees lock already counts as the first stable cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                cnt_d = '0;
                if (lock_s) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_QUAL;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_QUAL: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d    = ST_LOST;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d    = ST_LOST;
                    loss_event = 1'b1;
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // A loss on the same edge as a clear still sets the flag.
    always_comb begin
        lost_d = lost_q;
        if (loss_event) begin
            lost_d = 1'b1;
        end else if (i_clear) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= (state_d != ST_RUN);
            ready_q <= (state_d == ST_RUN);
            lost_q  <= lost_d;
        end
    end

    assign o_rst       = rst_q;
    assign o_ready     = ready_q;
    assign o_lock_lost = lost_q;

`ifdef PLL_LOCK_SUPERVISOR_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_event) begin
            if (i_clear) begin
                loss_cnt_d = LOSS_CNT_W'(1);
            end else if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
            end
        end else if (i_clear) begin
            loss_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_loss_count = loss_cnt_q;
`else
    assign o_loss_count = '0;
`endif

endmodule
